// File: rtl/icache_dataram_sched_pkg.sv
// rtl/icache_dataram_sched_pkg.sv - shared types and widths for the icache data SRAM scheduler
package icache_dataram_sched_pkg;

  localparam int ICACHE_WAY_NUM             = 2;
  localparam int ICACHE_WAY_WIDTH           = $clog2(ICACHE_WAY_NUM);
  localparam int ICACHE_INDEX_WIDTH         = 6;
  localparam int ICACHE_REQ_TXNID_WIDTH     = 4;
  localparam int ICACHE_UPSTREAM_DATA_WIDTH = 64;

  typedef struct packed {
    logic [ICACHE_WAY_WIDTH-1:0]       way;
    logic [ICACHE_INDEX_WIDTH-1:0]     index;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
  } dataram_rd_req_t;

  typedef struct packed {
    logic [ICACHE_WAY_WIDTH-1:0]           way;
    logic [ICACHE_INDEX_WIDTH-1:0]         index;
    logic [ICACHE_UPSTREAM_DATA_WIDTH-1:0] data;
  } dataram_wr_req_t;

  typedef struct packed {
    logic [ICACHE_UPSTREAM_DATA_WIDTH-1:0] data;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0]     txnid;
  } dataram_rsp_t;

  // A read may issue only if its data is guaranteed a slot in the 2-entry return FIFO.
  function automatic logic credit_ok(input logic [1:0] fifo_cnt, input logic inflight);
    return ({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd2;
  endfunction

endpackage

// File: rtl/icache_dataram_rsp_fifo.sv
// rtl/icache_dataram_rsp_fifo.sv - 2-entry synchronous FIFO holding SRAM read responses
module icache_dataram_rsp_fifo #(
  parameter int W = 68
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   cnt
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (cnt != 2'd2);
  assign do_pop  = pop && (cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr) mem1 <= push_data;
        else        mem0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_data = rd_ptr ? mem1 : mem0;

endmodule

// File: rtl/icache_dataram_sched.sv
// rtl/icache_dataram_sched.sv - single-port icache data SRAM arbiter with read aging and credited return FIFO
module icache_dataram_sched
  import icache_dataram_sched_pkg::*;
#(
  parameter int WAY_NUM    = ICACHE_WAY_NUM,
  parameter int INDEX_W    = ICACHE_INDEX_WIDTH,
  parameter int TXNID_W    = ICACHE_REQ_TXNID_WIDTH,
  parameter int DATA_W     = ICACHE_UPSTREAM_DATA_WIDTH,
  parameter int STARVE_MAX = 4,
  localparam int WW        = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_vld,
  output logic               rd_rdy,
  input  logic [WW-1:0]      rd_way,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TXNID_W-1:0] rd_txnid,
  input  logic               wr_vld,
  output logic               wr_rdy,
  input  logic [WW-1:0]      wr_way,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               ram_en,
  output logic               ram_we,
  output logic [WW-1:0]      ram_way,
  output logic [INDEX_W-1:0] ram_index,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata,
  output logic               txdat_vld,
  input  logic               txdat_rdy,
  output logic [DATA_W-1:0]  txdat_data,
  output logic [TXNID_W-1:0] txdat_txnid
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0]             starve_cnt;
  logic                      inflight;
  logic [TXNID_W-1:0]        inflight_txnid;
  logic [1:0]                fifo_cnt;
  logic [DATA_W+TXNID_W-1:0] fifo_head;
  logic                      credit;
  logic                      force_rd;
  logic                      rd_fire;
  logic                      wr_fire;

  assign credit   = credit_ok(fifo_cnt, inflight);
  assign force_rd = (starve_cnt == STARVE_LIM);

  // Writes win by default; once a creditable read has been passed over STARVE_MAX times it goes first.
  assign rd_rdy  = credit & (~wr_vld | force_rd);
  assign wr_rdy  = ~(force_rd & rd_vld & credit);
  assign rd_fire = rd_vld & rd_rdy;
  assign wr_fire = wr_vld & wr_rdy;

  assign ram_en    = rd_fire | wr_fire;
  assign ram_we    = wr_fire;
  assign ram_way   = rd_fire ? rd_way   : (wr_fire ? wr_way   : '0);
  assign ram_index = rd_fire ? rd_index : (wr_fire ? wr_index : '0);
  assign ram_wdata = wr_data;

  // Only a read that lost to a write ages; a read waiting on credit does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (rd_fire) begin
      starve_cnt <= '0;
    end else if (rd_vld && credit && wr_fire && !force_rd) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight       <= 1'b0;
      inflight_txnid <= '0;
    end else begin
      inflight <= rd_fire;
      if (rd_fire) inflight_txnid <= rd_txnid;
    end
  end

  // The credit check at issue time guarantees this push always finds a free slot.
  icache_dataram_rsp_fifo #(
    .W(DATA_W + TXNID_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({ram_rdata, inflight_txnid}),
    .pop       (txdat_vld & txdat_rdy),
    .head_data (fifo_head),
    .cnt       (fifo_cnt)
  );

  assign txdat_vld                 = (fifo_cnt != 2'd0);
  assign {txdat_data, txdat_txnid} = fifo_head;

endmodule

// File: tb/tb_icache_dataram_sched.sv
// tb/tb_icache_dataram_sched.sv - scoreboard bench for icache_dataram_sched
module tb_icache_dataram_sched;

  localparam int WW = 1;
  localparam int IW = 6;
  localparam int TW = 4;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_vld = 1'b0;
  logic          rd_rdy;
  logic [WW-1:0] rd_way = '0;
  logic [IW-1:0] rd_index = '0;
  logic [TW-1:0] rd_txnid = '0;
  logic          wr_vld = 1'b0;
  logic          wr_rdy;
  logic [WW-1:0] wr_way = '0;
  logic [IW-1:0] wr_index = '0;
  logic [DW-1:0] wr_data = '0;
  logic          ram_en;
  logic          ram_we;
  logic [WW-1:0] ram_way;
  logic [IW-1:0] ram_index;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          txdat_vld;
  logic          txdat_rdy = 1'b0;
  logic [DW-1:0] txdat_data;
  logic [TW-1:0] txdat_txnid;

  always #5 clk = ~clk;

  icache_dataram_sched #(
    .WAY_NUM(2), .INDEX_W(IW), .TXNID_W(TW), .DATA_W(DW), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_way(rd_way), .rd_index(rd_index), .rd_txnid(rd_txnid),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_way(wr_way), .wr_index(wr_index), .wr_data(wr_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_way(ram_way), .ram_index(ram_index),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .txdat_vld(txdat_vld), .txdat_rdy(txdat_rdy), .txdat_data(txdat_data), .txdat_txnid(txdat_txnid)
  );

  int total = 0;
  int bad = 0;

  logic [DW-1:0]    sram    [0:127];
  logic [DW-1:0]    exp_mem [0:127];
  logic [DW+TW-1:0] exp_q [$];

  logic          f_rd, f_wr, s_en, s_we, s_txvld, s_rd_rdy;
  logic [WW-1:0] s_way;
  logic [IW-1:0] s_idx;
  logic [DW-1:0] s_txdata;
  logic [TW-1:0] s_txnid;
  logic [2:0]    s_starve;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: entered at a negedge with inputs driven, samples just before the posedge.
  task automatic cyc();
    #4;
    f_rd     = rd_vld && rd_rdy;
    f_wr     = wr_vld && wr_rdy;
    s_en     = ram_en;
    s_we     = ram_we;
    s_way    = ram_way;
    s_idx    = ram_index;
    s_txvld  = txdat_vld;
    s_txdata = txdat_data;
    s_txnid  = txdat_txnid;
    s_rd_rdy = rd_rdy;
    s_starve = dut.starve_cnt;
    if (f_rd) exp_q.push_back({exp_mem[{rd_way, rd_index}], rd_txnid});
    if (f_wr) exp_mem[{wr_way, wr_index}] = wr_data;
    @(negedge clk);
  endtask

  // SRAM model: one-cycle read latency, write commits on the access edge.
  logic          m_en, m_we;
  logic [6:0]    m_addr;
  logic [DW-1:0] m_wd;
  initial begin
    ram_rdata = '0;
    forever begin
      @(negedge clk);
      #4;
      m_en   = ram_en;
      m_we   = ram_we;
      m_addr = {ram_way, ram_index};
      m_wd   = ram_wdata;
      @(posedge clk);
      #1;
      if (m_en && m_we) sram[m_addr] = m_wd;
      else if (m_en)    ram_rdata = sram[m_addr];
    end
  end

  // Monitor: every accepted upstream beat must match the oldest expected response.
  logic [DW+TW-1:0] e;
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && txdat_vld && txdat_rdy) begin
        if (exp_q.size() == 0) begin
          chk("txdat_unexpected", 64'(txdat_txnid), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("txdat_data", 64'(txdat_data), 64'(e[DW+TW-1:TW]));
          chk("txdat_txnid", 64'(txdat_txnid), 64'(e[TW-1:0]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int  k;
  int  seen;
  logic exp_r;

  initial begin
    for (int i = 0; i < 128; i++) begin
      sram[i]    = {32'hC0DE0000, 32'(i)};
      exp_mem[i] = {32'hC0DE0000, 32'(i)};
    end

    // Reset state
    #6;
    chk("rst_txdat_vld", 64'(txdat_vld), 64'd0);
    chk("rst_txdat_data", 64'(txdat_data), 64'd0);
    chk("rst_txdat_txnid", 64'(txdat_txnid), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_rd_rdy", 64'(rd_rdy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read, way 1, index 5, txnid 3
    txdat_rdy = 1'b1;
    rd_vld = 1'b1; rd_way = 1'b1; rd_index = 6'd5; rd_txnid = 4'd3;
    cyc();
    chk("single_ram_en", 64'(s_en), 64'd1);
    chk("single_ram_we", 64'(s_we), 64'd0);
    chk("single_ram_way", 64'(s_way), 64'd1);
    chk("single_ram_index", 64'(s_idx), 64'd5);
    rd_vld = 1'b0;
    cyc();
    chk("single_vld_t1", 64'(s_txvld), 64'd0);
    cyc();
    chk("single_vld_t2", 64'(s_txvld), 64'd1);
    chk("single_txnid_t2", 64'(s_txnid), 64'd3);

    // Aging: four writes then one forced read, repeating
    rd_vld = 1'b1; wr_vld = 1'b1;
    rd_way = 1'b0; rd_index = 6'd9; wr_way = 1'b0; wr_index = 6'd9;
    for (int c = 0; c < 10; c++) begin
      rd_txnid = 4'(c);
      wr_data  = {32'hBEEF0000, 32'(c)};
      cyc();
      exp_r = ((c % 5) == 4);
      chk("starve_rd_fire", 64'(f_rd), 64'(exp_r));
      chk("starve_wr_fire", 64'(f_wr), 64'(!exp_r));
      if (exp_r) begin
        chk("starve_cnt_forced", 64'(s_starve), 64'd4);
        chk("starve_cnt_cleared", 64'(dut.starve_cnt), 64'd0);
      end
    end
    rd_vld = 1'b0; wr_vld = 1'b0;
    repeat (3) cyc();

    // Upstream backpressure: only two reads accepted, then release
    txdat_rdy = 1'b0; rd_vld = 1'b1; rd_way = 1'b1; k = 0;
    for (int c = 0; c < 6; c++) begin
      rd_index = 6'(10 + k); rd_txnid = 4'(k);
      cyc();
      if (f_rd) k++;
    end
    chk("bp_accepted", 64'(k), 64'd2);
    chk("bp_rd_rdy_low", 64'(s_rd_rdy), 64'd0);
    txdat_rdy = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      rd_index = 6'(10 + k); rd_txnid = 4'(k);
      cyc();
      if (f_rd) k++;
    end
    chk("bp_all_accepted", 64'(k), 64'd4);
    rd_vld = 1'b0;
    repeat (4) cyc();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Write then read-after-write next cycle
    wr_vld = 1'b1; wr_way = 1'b0; wr_index = 6'd7; wr_data = 64'hA5A5A5A5A5A5A5A5;
    cyc();
    chk("raw_wr_fire", 64'(f_wr), 64'd1);
    wr_vld = 1'b0;
    rd_vld = 1'b1; rd_way = 1'b0; rd_index = 6'd7; rd_txnid = 4'd5;
    cyc();
    chk("raw_rd_fire", 64'(f_rd), 64'd1);
    rd_vld = 1'b0;
    cyc();
    cyc();
    chk("raw_txdat_data", 64'(s_txdata), 64'hA5A5A5A5A5A5A5A5);

    // FIFO at count 1 with simultaneous push and pop
    txdat_rdy = 1'b0;
    rd_vld = 1'b1; rd_way = 1'b1; rd_index = 6'd20; rd_txnid = 4'd6;
    cyc();
    chk("pp_rd_x", 64'(f_rd), 64'd1);
    rd_index = 6'd21; rd_txnid = 4'd7;
    cyc();
    chk("pp_rd_y", 64'(f_rd), 64'd1);
    rd_vld = 1'b0; txdat_rdy = 1'b1;
    cyc();
    chk("pp_head_txnid", 64'(s_txnid), 64'd6);
    chk("pp_cnt_hold", 64'(dut.fifo_cnt), 64'd1);
    repeat (3) cyc();
    chk("pp_drained", 64'(exp_q.size()), 64'd0);

    // Reset while a read response is in flight
    rd_vld = 1'b1; rd_way = 1'b0; rd_index = 6'd30; rd_txnid = 4'd8;
    cyc();
    chk("rr_rd_fire", 64'(f_rd), 64'd1);
    wr_vld = 1'b1; wr_way = 1'b0; wr_index = 6'd31; wr_data = 64'h1234;
    cyc();
    chk("rr_wr_fire", 64'(f_wr), 64'd1);
    chk("rr_pre_starve", 64'(dut.starve_cnt), 64'd1);
    rst_n = 1'b0; rd_vld = 1'b0; wr_vld = 1'b0;
    #1;
    chk("rr_starve_reset", 64'(dut.starve_cnt), 64'd0);
    chk("rr_vld_reset", 64'(txdat_vld), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      cyc();
      if (s_txvld) seen++;
    end
    chk("rr_no_vld_after", 64'(seen), 64'd0);
    chk("rr_starve_after", 64'(dut.starve_cnt), 64'd0);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
